// File: rtl/enc8b10b_tx_sched.sv
// Transmit symbol scheduler feeding a combinational 8b/10b encoder.
// Ports: clk/rst, en strobe, s_* payload in, enc_word back, sym_* / flags out.
module enc8b10b_tx_sched #(
  parameter int unsigned COMMA_INTERVAL = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  input  logic [9:0] enc_word,
  output logic [7:0] sym_data,
  output logic       sym_k,
  output logic       sym_rd,
  output logic       comma_ins,
  output logic       err_disp
);

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K23_7 = 8'hF7;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(COMMA_INTERVAL - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_EOF
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             comma_due;

  logic [7:0] data_d;
  logic       k_d;
  logic       ci_d;
  logic       is_comma;

  logic [3:0] ones;
  logic       rd_d;
  logic       derr;

  assign comma_due = (cnt_q == CNT_MAX);

  assign s_ready = en && (state_q == ST_DATA)
                   && !comma_due && !rst;

  // Ones count of the word the encoder produced
  // for the symbol currently on sym_*.
  always_comb begin
    ones = '0;
    for (int i = 0; i < 10; i++) begin
      ones = ones + {3'b000, enc_word[i]};
    end
  end

  // Running disparity check and update. An
  // illegal word leaves RD where it was.
  always_comb begin
    rd_d = sym_rd;
    derr = 1'b0;
    unique case (ones)
      4'd5: rd_d = sym_rd;
      4'd6: begin
        if (!sym_rd) rd_d = 1'b1;
        else         derr = 1'b1;
      end
      4'd4: begin
        if (sym_rd) rd_d = 1'b0;
        else        derr = 1'b1;
      end
      default: derr = 1'b1;
    endcase
  end

  // Symbol selection. Default slot content is
  // a K28.5 comma/fill.
  always_comb begin
    state_d  = state_q;
    data_d   = K28_5;
    k_d      = 1'b1;
    ci_d     = 1'b0;
    is_comma = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        // SOF is never preempted by comma_due.
        if (s_valid) begin
          data_d   = K28_1;
          is_comma = 1'b0;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (comma_due) begin
          ci_d = 1'b1;
        end else if (s_valid) begin
          data_d   = s_data;
          k_d      = 1'b0;
          is_comma = 1'b0;
          if (s_last) state_d = ST_EOF;
        end
      end
      ST_EOF: begin
        data_d   = K23_7;
        is_comma = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Symbols since the last comma, saturating.
  always_comb begin
    if (is_comma)       cnt_d = '0;
    else if (comma_due) cnt_d = cnt_q;
    else                cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sym_data  <= K28_5;
      sym_k     <= 1'b1;
      sym_rd    <= 1'b0;
      comma_ins <= 1'b0;
      err_disp  <= 1'b0;
    end else if (en) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sym_data  <= data_d;
      sym_k     <= k_d;
      sym_rd    <= rd_d;
      comma_ins <= ci_d;
      err_disp  <= err_disp | derr;
    end else begin
      comma_ins <= 1'b0;
    end
  end

endmodule

// File: tb/tb_enc8b10b_tx_sched.sv
// Directed bench for enc8b10b_tx_sched (COMMA_INTERVAL=4).
// A small model encoder feeds enc_word back from the sym_* outputs.
module tb_enc8b10b_tx_sched;

  logic       clk;
  logic       rst;
  logic       en;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;
  logic [9:0] enc_word;
  logic [7:0] sym_data;
  logic       sym_k;
  logic       sym_rd;
  logic       comma_ins;
  logic       err_disp;

  logic       ovr;
  logic [9:0] ovr_word;

  int errors;
  int checks;
  int idx;
  int sr_cnt;
  logic [7:0] bq[$];
  logic       lq[$];

  enc8b10b_tx_sched #(
    .COMMA_INTERVAL(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_last(s_last),
    .s_ready(s_ready),
    .enc_word(enc_word),
    .sym_data(sym_data),
    .sym_k(sym_k),
    .sym_rd(sym_rd),
    .comma_ins(comma_ins),
    .err_disp(err_disp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model encoder: K symbols flip RD, data is balanced.
  always_comb begin
    if (ovr)        enc_word = ovr_word;
    else if (sym_k) enc_word = sym_rd ? 10'b1100000101
                                      : 10'b0011111010;
    else            enc_word = 10'b1010101010;
  end

  task automatic chk(input string tag,
                     input logic [9:0] obs,
                     input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sym(input string tag,
                     input logic [7:0] d,
                     input logic k,
                     input logic ci);
    chk({tag, ".data"}, {2'b00, sym_data}, {2'b00, d});
    chk({tag, ".k"}, {9'd0, sym_k}, {9'd0, k});
    chk({tag, ".ci"}, {9'd0, comma_ins}, {9'd0, ci});
  endtask

  // One en=1 slot fed from the byte queue.
  task automatic fstep(input string tag,
                       input logic [7:0] d,
                       input logic k,
                       input logic ci,
                       input logic sr);
    logic seen;
    s_valid = (idx < bq.size());
    s_data  = s_valid ? bq[idx] : 8'h00;
    s_last  = s_valid ? lq[idx] : 1'b0;
    #1;
    seen = s_ready;
    chk({tag, ".s_ready"}, {9'd0, seen}, {9'd0, sr});
    tick();
    sym(tag, d, k, ci);
    if (seen) begin
      idx++;
      sr_cnt++;
    end
  endtask

  initial begin
    logic [7:0] d2[7];
    logic       k2[7];
    logic       c2[7];
    logic       r2[7];
    logic [7:0] d3[16];
    logic       k3[16];
    logic       c3[16];
    logic       r3[16];
    logic [7:0] d4[9];
    logic       k4[9];
    logic       c4[9];
    logic       r4[9];
    logic       rd1[4];

    errors   = 0;
    checks   = 0;
    ovr      = 1'b0;
    ovr_word = '0;
    rst      = 1'b1;
    en       = 1'b1;
    s_valid  = 1'b1;
    s_data   = 8'h00;
    s_last   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst.s_ready", {9'd0, s_ready}, 10'd0);
    sym("rst", 8'hBC, 1'b1, 1'b0);
    chk("rst.rd", {9'd0, sym_rd}, 10'd0);
    chk("rst.err", {9'd0, err_disp}, 10'd0);

    // Idle commas, RD toggles each slot
    rst     = 1'b0;
    s_valid = 1'b0;
    rd1 = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("idle.s_ready", {9'd0, s_ready}, 10'd0);
      tick();
      sym("idle", 8'hBC, 1'b1, 1'b0);
      chk("idle.rd", {9'd0, sym_rd}, {9'd0, rd1[i]});
    end

    // 3-byte frame; comma lands after A2
    bq = '{8'hA1, 8'hA2, 8'hA3};
    lq = '{1'b0, 1'b0, 1'b1};
    idx = 0;
    sr_cnt = 0;
    d2 = '{8'h3C, 8'hA1, 8'hA2, 8'hBC, 8'hA3, 8'hF7, 8'hBC};
    k2 = '{1, 0, 0, 1, 0, 1, 1};
    c2 = '{0, 0, 0, 1, 0, 0, 0};
    r2 = '{0, 1, 1, 0, 1, 0, 0};
    for (int i = 0; i < 7; i++)
      fstep("f3", d2[i], k2[i], c2[i], r2[i]);
    chk("f3.nready", sr_cnt[9:0], 10'd3);

    // 10-byte frame, s_valid always high
    bq = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4,
           8'hD5, 8'hD6, 8'hD7, 8'hD8, 8'hD9};
    lq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    idx = 0;
    sr_cnt = 0;
    d3 = '{8'h3C, 8'hD0, 8'hD1, 8'hBC,
           8'hD2, 8'hD3, 8'hD4, 8'hBC,
           8'hD5, 8'hD6, 8'hD7, 8'hBC,
           8'hD8, 8'hD9, 8'hF7, 8'hBC};
    k3 = '{1, 0, 0, 1, 0, 0, 0, 1,
           0, 0, 0, 1, 0, 0, 1, 1};
    c3 = '{0, 0, 0, 1, 0, 0, 0, 1,
           0, 0, 0, 1, 0, 0, 0, 0};
    r3 = '{0, 1, 1, 0, 1, 1, 1, 0,
           1, 1, 1, 0, 1, 1, 0, 0};
    for (int i = 0; i < 16; i++)
      fstep("f10", d3[i], k3[i], c3[i], r3[i]);
    chk("f10.nready", sr_cnt[9:0], 10'd10);
    chk("f10.err", {9'd0, err_disp}, 10'd0);

    // Back-to-back frames with en toggling
    bq = '{8'hE0, 8'hE1, 8'hE2};
    lq = '{1'b0, 1'b1, 1'b1};
    idx = 0;
    d4 = '{8'h3C, 8'hE0, 8'hE1, 8'hF7, 8'h3C,
           8'hBC, 8'hE2, 8'hF7, 8'hBC};
    k4 = '{1, 0, 0, 1, 1, 1, 0, 1, 1};
    c4 = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    r4 = '{0, 1, 1, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 9; i++) begin
      en = 1'b1;
      fstep("b2b", d4[i], k4[i], c4[i], r4[i]);
      en = 1'b0;
      #1;
      chk("hold.s_ready", {9'd0, s_ready}, 10'd0);
      tick();
      sym("hold", d4[i], k4[i], 1'b0);
    end
    en = 1'b1;

    // Disparity error: 3 ones
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ovr = 1'b1;
    ovr_word = 10'b0000000111;
    tick();
    chk("err3.err", {9'd0, err_disp}, 10'd1);
    chk("err3.rd", {9'd0, sym_rd}, 10'd0);
    ovr = 1'b0;
    tick();
    chk("errsticky.err", {9'd0, err_disp}, 10'd1);
    chk("errsticky.rd", {9'd0, sym_rd}, 10'd1);

    // Disparity error: 6 ones at RD+
    rst = 1'b1;
    tick();
    chk("errclr.err", {9'd0, err_disp}, 10'd0);
    rst = 1'b0;
    tick();
    chk("rdp.rd", {9'd0, sym_rd}, 10'd1);
    chk("rdp.err", {9'd0, err_disp}, 10'd0);
    ovr = 1'b1;
    ovr_word = 10'b0011111010;
    tick();
    chk("err6.err", {9'd0, err_disp}, 10'd1);
    chk("err6.rd", {9'd0, sym_rd}, 10'd1);
    ovr = 1'b0;

    // Reset mid-frame
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bq = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    lq = '{0, 0, 0, 0, 1};
    idx = 0;
    fstep("mid", 8'h3C, 1'b1, 1'b0, 1'b0);
    fstep("mid", 8'hB0, 1'b0, 1'b0, 1'b1);
    fstep("mid", 8'hB1, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    s_valid = 1'b1;
    s_data = 8'hB2;
    #1;
    chk("midrst.s_ready", {9'd0, s_ready}, 10'd0);
    tick();
    sym("midrst", 8'hBC, 1'b1, 1'b0);
    chk("midrst.rd", {9'd0, sym_rd}, 10'd0);
    rst = 1'b0;
    s_data = 8'hC0;
    s_last = 1'b0;
    #1;
    chk("newsof.s_ready", {9'd0, s_ready}, 10'd0);
    tick();
    sym("newsof", 8'h3C, 1'b1, 1'b0);
    chk("newsof.err", {9'd0, err_disp}, 10'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
